// File: rtl/ddr_rdata_to_pkts.sv
// ddr_rdata_to_pkts: buffers DDR3 read-reply beats and re-emits them as NoC reply packets, one per frame.
// Defining DDR2PKT_STATS_EN adds the frames_sent and max_fill statistics outputs.
module ddr_rdata_to_pkts #(
    parameter int AVL_DATA_WIDTH  = 512,
    parameter int FRAME_ID_WIDTH  = 32,
    parameter int BEATS_PER_FRAME = 8,
    parameter int DATA_DEPTH      = 16,
    parameter int ID_DEPTH        = 4,
    parameter int WIDTH_PKT       = AVL_DATA_WIDTH + 2 + FRAME_ID_WIDTH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               rd_issue,
    input  logic [FRAME_ID_WIDTH-1:0]          rd_frame_id,
    output logic                               rd_allow,
    input  logic [AVL_DATA_WIDTH-1:0]          avl_readdata,
    input  logic                               avl_readdatavalid,
    output logic [WIDTH_PKT-1:0]               noc_data_out,
    output logic [3:0]                         noc_valid_out,
    output logic [3:0]                         noc_sop_out,
    output logic [3:0]                         noc_eop_out,
    input  logic                               noc_ready_in,
`ifdef DDR2PKT_STATS_EN
    output logic [31:0]                        frames_sent,
    output logic [$clog2(DATA_DEPTH+1)-1:0]    max_fill,
`endif
    output logic                               err_overflow,
    output logic                               err_reject
);

    localparam int CW  = $clog2(DATA_DEPTH + 1);
    localparam int DAW = $clog2(DATA_DEPTH);
    localparam int IAW = $clog2(ID_DEPTH);
    localparam int IW  = $clog2(ID_DEPTH + 1);
    localparam int BW  = $clog2(BEATS_PER_FRAME);

    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    logic [AVL_DATA_WIDTH-1:0] r_data_mem [DATA_DEPTH];
    logic [FRAME_ID_WIDTH-1:0] r_id_mem   [ID_DEPTH];
    logic [DAW-1:0]            r_data_wr_ptr, r_data_rd_ptr;
    logic [CW-1:0]             r_data_count, r_outstanding;
    logic [IAW-1:0]            r_id_wr_ptr, r_id_rd_ptr;
    logic [IW-1:0]             r_id_count;
    logic [BW-1:0]             r_beat_cnt;
    logic                      r_rd_allow, r_err_overflow, r_err_reject;
    state_t                    r_state, w_state_nxt;

    logic          w_present, w_pop, w_last, w_id_pop, w_push, w_drop;
    logic          w_issue_ok, w_reject, w_data_full, w_allow_nxt;
    logic [CW-1:0] w_data_count_nxt, w_outstanding_nxt;
    logic [IW-1:0] w_id_count_nxt;
    logic [CW+1:0] w_fill_sum;

    assign w_data_full = (r_data_count == CW'(DATA_DEPTH));
    assign w_present   = (r_data_count != '0) && (r_id_count != '0);
    assign w_pop       = w_present && noc_ready_in;
    assign w_last      = (r_beat_cnt == BW'(BEATS_PER_FRAME - 1));
    assign w_id_pop    = w_pop && w_last;
    // A full FIFO still takes a beat when its head leaves in the same cycle.
    assign w_push      = avl_readdatavalid && (!w_data_full || w_pop);
    assign w_drop      = avl_readdatavalid && w_data_full && !w_pop;
    assign w_issue_ok  = rd_issue && r_rd_allow;
    assign w_reject    = rd_issue && !r_rd_allow;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_data_count_nxt  = r_data_count + CW'(w_push) - CW'(w_pop);
        w_id_count_nxt    = r_id_count + IW'(w_issue_ok) - IW'(w_id_pop);
        w_outstanding_nxt = r_outstanding;
        if (w_issue_ok)
            w_outstanding_nxt = w_outstanding_nxt + CW'(BEATS_PER_FRAME);
        // Unsolicited beats must not drive the reservation count below zero.
        if (avl_readdatavalid && (w_outstanding_nxt != '0))
            w_outstanding_nxt = w_outstanding_nxt - 1'b1;
        w_fill_sum  = (CW+2)'(w_data_count_nxt) + (CW+2)'(w_outstanding_nxt)
                    + (CW+2)'(BEATS_PER_FRAME);
        w_allow_nxt = (w_fill_sum <= (CW+2)'(DATA_DEPTH)) && (w_id_count_nxt != IW'(ID_DEPTH));
    end

    always_comb begin
        w_state_nxt   = r_state;
        noc_data_out  = '0;
        noc_valid_out = 4'b0000;
        noc_sop_out   = 4'b0000;
        noc_eop_out   = 4'b0000;
        case (r_state)
            ST_IDLE: if (w_present) w_state_nxt = ST_SEND;
            ST_SEND: if (w_id_pop && (w_data_count_nxt == '0)) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_present) begin
            noc_data_out  = {1'b0, 1'b1, r_id_mem[r_id_rd_ptr], r_data_mem[r_data_rd_ptr]};
            noc_valid_out = 4'b1111;
            noc_sop_out   = (r_beat_cnt == '0) ? 4'b1000 : 4'b0000;
            noc_eop_out   = w_last ? 4'b0001 : 4'b0000;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_wr_ptr  <= '0;
            r_data_rd_ptr  <= '0;
            r_data_count   <= '0;
            r_id_wr_ptr    <= '0;
            r_id_rd_ptr    <= '0;
            r_id_count     <= '0;
            r_outstanding  <= '0;
            r_beat_cnt     <= '0;
            r_rd_allow     <= 1'b1;
            r_err_overflow <= 1'b0;
            r_err_reject   <= 1'b0;
        end else begin
            r_data_count  <= w_data_count_nxt;
            r_id_count    <= w_id_count_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_rd_allow    <= w_allow_nxt;
            if (w_push)
                r_data_wr_ptr <= (r_data_wr_ptr == DAW'(DATA_DEPTH - 1)) ? '0 : r_data_wr_ptr + 1'b1;
            if (w_pop)
                r_data_rd_ptr <= (r_data_rd_ptr == DAW'(DATA_DEPTH - 1)) ? '0 : r_data_rd_ptr + 1'b1;
            if (w_issue_ok)
                r_id_wr_ptr <= (r_id_wr_ptr == IAW'(ID_DEPTH - 1)) ? '0 : r_id_wr_ptr + 1'b1;
            if (w_id_pop)
                r_id_rd_ptr <= (r_id_rd_ptr == IAW'(ID_DEPTH - 1)) ? '0 : r_id_rd_ptr + 1'b1;
            if (w_pop)
                r_beat_cnt <= w_last ? '0 : r_beat_cnt + 1'b1;
            if (w_drop)
                r_err_overflow <= 1'b1;
            if (w_reject)
                r_err_reject <= 1'b1;
        end
    end

    // NOTE: storage arrays are left unreset; the counts and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (w_push)
            r_data_mem[r_data_wr_ptr] <= avl_readdata;
        if (w_issue_ok)
            r_id_mem[r_id_wr_ptr] <= rd_frame_id;
    end

`ifdef DDR2PKT_STATS_EN
    logic [31:0]   r_frames_sent;
    logic [CW-1:0] r_max_fill;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frames_sent <= '0;
            r_max_fill    <= '0;
        end else begin
            if (w_id_pop)
                r_frames_sent <= r_frames_sent + 32'd1;
            if (w_data_count_nxt > r_max_fill)
                r_max_fill <= w_data_count_nxt;
        end
    end

    assign frames_sent = r_frames_sent;
    assign max_fill    = r_max_fill;
`endif

    assign rd_allow     = r_rd_allow;
    assign err_overflow = r_err_overflow;
    assign err_reject   = r_err_reject;

endmodule

// File: tb/tb_ddr_rdata_to_pkts.sv
// Bench for ddr_rdata_to_pkts: directed frames; expected beats queued at stimulus time
// and compared by a negedge monitor whenever the DUT transfers a beat.
module tb_ddr_rdata_to_pkts;

    localparam int AW  = 512;
    localparam int IDW = 32;
    localparam int BPF = 8;
    localparam int WP  = AW + 2 + IDW;

    typedef struct packed {
        logic [WP-1:0] pkt;
        logic [3:0]    sop;
        logic [3:0]    eop;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           rd_issue = 1'b0;
    logic [IDW-1:0] rd_frame_id = '0;
    logic           rd_allow;
    logic [AW-1:0]  avl_readdata = '0;
    logic           avl_readdatavalid = 1'b0;
    logic [WP-1:0]  noc_data_out;
    logic [3:0]     noc_valid_out, noc_sop_out, noc_eop_out;
    logic           noc_ready_in = 1'b0;
    logic           err_overflow, err_reject;
`ifdef DDR2PKT_STATS_EN
    logic [31:0]    frames_sent;
    logic [4:0]     max_fill;
`endif

    exp_t          exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    logic          held_v = 1'b0;
    logic [WP-1:0] held_pkt;
    logic [3:0]    held_sop, held_eop;

    ddr_rdata_to_pkts dut (
        .clk               (clk),
        .rst               (rst),
        .rd_issue          (rd_issue),
        .rd_frame_id       (rd_frame_id),
        .rd_allow          (rd_allow),
        .avl_readdata      (avl_readdata),
        .avl_readdatavalid (avl_readdatavalid),
        .noc_data_out      (noc_data_out),
        .noc_valid_out     (noc_valid_out),
        .noc_sop_out       (noc_sop_out),
        .noc_eop_out       (noc_eop_out),
        .noc_ready_in      (noc_ready_in),
`ifdef DDR2PKT_STATS_EN
        .frames_sent       (frames_sent),
        .max_fill          (max_fill),
`endif
        .err_overflow      (err_overflow),
        .err_reject        (err_reject)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [639:0] act, input logic [639:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [AW-1:0] pat(input int k);
        logic [31:0] w;
        w = 32'hD0D0_0000 + k;
        return {16{w}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        rd_issue = 1'b0;
        avl_readdatavalid = 1'b0;
        noc_ready_in = 1'b0;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic issue(input logic [IDW-1:0] id);
        rd_issue = 1'b1;
        rd_frame_id = id;
        tick();
        rd_issue = 1'b0;
    endtask

    task automatic send_frame(input logic [IDW-1:0] id, input int base, input bit toggle);
        for (int k = 0; k < BPF; k++) begin
            exp_t e;
            e.pkt = {1'b0, 1'b1, id, pat(base + k)};
            e.sop = (k == 0) ? 4'b1000 : 4'b0000;
            e.eop = (k == BPF - 1) ? 4'b0001 : 4'b0000;
            exp_q.push_back(e);
            avl_readdatavalid = 1'b1;
            avl_readdata = pat(base + k);
            if (toggle) noc_ready_in = ~noc_ready_in;
            tick();
        end
        avl_readdatavalid = 1'b0;
        avl_readdata = '0;
    endtask

    task automatic drain(input int budget, input bit toggle);
        int i = 0;
        while ((exp_q.size() != 0 || noc_valid_out != 4'b0000) && i < budget) begin
            if (toggle) noc_ready_in = ~noc_ready_in;
            else        noc_ready_in = 1'b1;
            tick();
            i++;
        end
        check("drain_left", 32'(exp_q.size()) + 32'(noc_valid_out != 4'b0000), 0);
    endtask

    // Monitor: compares each transferred beat with the queue head and checks that a
    // stalled beat stays put until it is taken.
    always @(negedge clk) begin
        if (!rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("hold_pkt", noc_data_out, held_pkt);
                check("hold_sop", noc_sop_out, held_sop);
                check("hold_eop", noc_eop_out, held_eop);
            end
            if (noc_valid_out != 4'b0000) begin
                if (noc_ready_in) begin
                    held_v = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_beat: got %0h expected no beat", noc_data_out);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("beat_pkt", noc_data_out, e.pkt);
                        check("beat_sop", noc_sop_out, e.sop);
                        check("beat_eop", noc_eop_out, e.eop);
                        check("beat_valid", noc_valid_out, 4'b1111);
                    end
                end else begin
                    held_v   = 1'b1;
                    held_pkt = noc_data_out;
                    held_sop = noc_sop_out;
                    held_eop = noc_eop_out;
                end
            end else begin
                held_v = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick();
        check("rst_rd_allow", rd_allow, 1);
        check("rst_valid", noc_valid_out, 0);
        check("rst_sop", noc_sop_out, 0);
        check("rst_eop", noc_eop_out, 0);
        check("rst_data", noc_data_out, 0);
        check("rst_err_overflow", err_overflow, 0);
        check("rst_err_reject", err_reject, 0);
        do_reset();

        // 1: single frame, ready held high
        noc_ready_in = 1'b1;
        issue(32'h5);
        check("t1_allow_after_issue", rd_allow, 1);
        send_frame(32'h5, 32'h00, 1'b0);
        drain(40, 1'b0);
        tick();
        check("t1_allow_end", rd_allow, 1);
        check("t1_err_overflow", err_overflow, 0);
        check("t1_err_reject", err_reject, 0);

        // 2: two frames fill the reservation, third issue rejected
        do_reset();
        noc_ready_in = 1'b1;
        issue(32'h21);
        check("t2_allow_after_1st", rd_allow, 1);
        issue(32'h22);
        check("t2_allow_after_2nd", rd_allow, 0);
        issue(32'h23);
        check("t2_err_reject", err_reject, 1);
        send_frame(32'h21, 32'h10, 1'b0);
        send_frame(32'h22, 32'h18, 1'b0);
        drain(60, 1'b0);
        repeat (4) tick();
        check("t2_allow_end", rd_allow, 1);
        check("t2_err_reject_sticky", err_reject, 1);
        issue(32'h24);
        send_frame(32'h24, 32'h20, 1'b0);
        drain(40, 1'b0);

        // 3: 16 beats buffered under backpressure
        do_reset();
        issue(32'h31);
        issue(32'h32);
        send_frame(32'h31, 32'h30, 1'b0);
        send_frame(32'h32, 32'h38, 1'b0);
        repeat (4) tick();
        check("t3_err_overflow", err_overflow, 0);
        check("t3_allow_full", rd_allow, 0);
        drain(60, 1'b0);
        tick();
        check("t3_allow_end", rd_allow, 1);

        // 4: 17 unsolicited beats with ready low, 17th dropped
        do_reset();
        for (int k = 0; k < 17; k++) begin
            avl_readdatavalid = 1'b1;
            avl_readdata = pat(32'h40 + k);
            tick();
        end
        avl_readdatavalid = 1'b0;
        check("t4_err_overflow", err_overflow, 1);
        check("t4_allow_full", rd_allow, 0);
        check("t4_valid_no_id", noc_valid_out, 0);
        noc_ready_in = 1'b1;
        repeat (3) tick();
        check("t4_err_overflow_sticky", err_overflow, 1);

        // 5: ready toggling each cycle
        do_reset();
        issue(32'h55);
        send_frame(32'h55, 32'h50, 1'b1);
        drain(60, 1'b1);

        // 6: reset asserted while beat 3 is presented
        do_reset();
        issue(32'h66);
        send_frame(32'h66, 32'h60, 1'b0);
        noc_ready_in = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        noc_ready_in = 1'b0;
        #1;
        check("t6_valid", noc_valid_out, 0);
        check("t6_sop", noc_sop_out, 0);
        check("t6_eop", noc_eop_out, 0);
        check("t6_data", noc_data_out, 0);
        check("t6_rd_allow", rd_allow, 1);
        exp_q.delete();
        #2;
        rst = 1'b1;
        tick();
        noc_ready_in = 1'b1;
        issue(32'h67);
        send_frame(32'h67, 32'h68, 1'b0);
        drain(40, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
